// File: rtl/sym_ex_loop.sv
// Location-encoded symbolic-execution benchmark: a bounded loop over free inputs
// a, b, c with data registers X, Y, Z, a start/done handshake and an absorbing error location.
module sym_ex_loop #(
    parameter int W        = 8,
    parameter int LIMIT    = 5,
    parameter int TARGET   = 4,
    parameter int MAX_ITER = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         loc_ok,
    output logic [3:0]   iter,
    output logic [W-1:0] x_out,
    output logic [W-1:0] y_out,
    output logic [W-1:0] z_out,
    output logic         prop
);

    typedef enum logic [3:0] {
        L_IDLE  = 4'd0,
        L_INIT  = 4'd1,
        L_TESTA = 4'd2,
        L_TESTB = 4'd3,
        L_THEN  = 4'd4,
        L_ZSET  = 4'd5,
        L_JOIN  = 4'd6,
        L_CHECK = 4'd7,
        L_OK    = 4'd8,
        L_ERR   = 4'd9
    } loc_e;

    localparam int NLOC = 10;

    localparam logic [W-1:0] LIMIT_W    = W'(LIMIT);
    localparam logic [W-1:0] TARGET_W   = W'(TARGET);
    localparam logic [3:0]   MAX_ITER_L = 4'(MAX_ITER);

    logic [NLOC-1:0] loc_q, loc_d;
    logic            loc_ok_q;
    logic [W-1:0]    x_q, x_d;
    logic [W-1:0]    y_q, y_d;
    logic [W-1:0]    z_q, z_d;
    logic [3:0]      iter_q, iter_d;
    logic [3:0]      iter_inc;
    logic [W-1:0]    sum;

    function automatic logic [NLOC-1:0] enc(input loc_e l);
        logic [NLOC-1:0] v;
        v    = '0;
        v[l] = 1'b1;
        return v;
    endfunction

    assign iter_inc = iter_q + 4'd1;
    assign sum      = x_q + y_q;

    // State register; loc_ok tracks whether the location vector was one-hot last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loc_q    <= enc(L_IDLE);
            loc_ok_q <= 1'b1;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            iter_q   <= '0;
        end else begin
            loc_q    <= loc_d;
            loc_ok_q <= $onehot(loc_q);
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            iter_q   <= iter_d;
        end
    end

    // A corrupted location vector freezes every register so the checker can observe it.
    always_comb begin
        loc_d  = loc_q;
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        iter_d = iter_q;
        if (loc_ok_q) begin
            if (loc_q[L_IDLE]) begin
                if (start) loc_d = enc(L_INIT);
            end else if (loc_q[L_INIT]) begin
                x_d    = '0;
                y_d    = '0;
                z_d    = '0;
                iter_d = '0;
                loc_d  = enc(L_TESTA);
            end else if (loc_q[L_TESTA]) begin
                if (a != '0) x_d = x_q + W'(3);
                loc_d = enc(L_TESTB);
            end else if (loc_q[L_TESTB]) begin
                loc_d = (b < LIMIT_W) ? enc(L_THEN) : enc(L_JOIN);
            end else if (loc_q[L_THEN]) begin
                y_d   = (a == '0 && c != '0) ? W'(2) : c;
                loc_d = enc(L_ZSET);
            end else if (loc_q[L_ZSET]) begin
                z_d   = W'(2);
                loc_d = enc(L_JOIN);
            end else if (loc_q[L_JOIN]) begin
                iter_d = iter_inc;
                loc_d  = (iter_inc < MAX_ITER_L) ? enc(L_TESTA) : enc(L_CHECK);
            end else if (loc_q[L_CHECK]) begin
                loc_d = (sum == TARGET_W) ? enc(L_ERR) : enc(L_OK);
            end else if (loc_q[L_OK]) begin
                if (start) loc_d = enc(L_INIT);
            end
        end
    end

    assign busy   = !(loc_q[L_IDLE] | loc_q[L_OK] | loc_q[L_ERR]);
    assign done   = loc_q[L_OK];
    assign err    = loc_q[L_ERR];
    assign prop   = !loc_q[L_ERR];
    assign loc_ok = loc_ok_q;
    assign iter   = iter_q;
    assign x_out  = x_q;
    assign y_out  = y_q;
    assign z_out  = z_q;

endmodule

// File: tb/tb_sym_ex_loop.sv
// Scoreboard bench for sym_ex_loop: two instances (MAX_ITER=1 and 2) share stimulus;
// each run's expected end state and latency is queued and checked when the run terminates.
module tb_sym_ex_loop;

    typedef struct {
        bit          er;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [7:0]  z;
        logic [3:0]  it;
        int          lat;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a, b, c;

    logic       busy1, done1, err1, lok1, prop1;
    logic [3:0] iter1;
    logic [7:0] x1, y1, z1;
    logic       busy2, done2, err2, lok2, prop2;
    logic [3:0] iter2;
    logic [7:0] x2, y2, z2;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    bit   prev1, prev2;

    int checks      = 0;
    int errors      = 0;
    int cycle       = 0;
    int start_cycle = 0;

    sym_ex_loop #(.W(8), .LIMIT(5), .TARGET(4), .MAX_ITER(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c),
        .busy(busy1), .done(done1), .err(err1), .loc_ok(lok1), .iter(iter1),
        .x_out(x1), .y_out(y1), .z_out(z1), .prop(prop1)
    );

    sym_ex_loop #(.W(8), .LIMIT(5), .TARGET(4), .MAX_ITER(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c),
        .busy(busy2), .done(done2), .err(err2), .loc_ok(lok2), .iter(iter2),
        .x_out(x2), .y_out(y2), .z_out(z2), .prop(prop2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle = cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkRun(input string name, input exp_t e, input logic er, input logic dn,
                            input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                            input logic [3:0] it);
        checkOutput({name, "_err"},  int'(er), int'(e.er));
        checkOutput({name, "_done"}, int'(dn), int'(!e.er));
        checkOutput({name, "_x"},    int'(x),  int'(e.x));
        checkOutput({name, "_y"},    int'(y),  int'(e.y));
        checkOutput({name, "_z"},    int'(z),  int'(e.z));
        checkOutput({name, "_iter"}, int'(it), int'(e.it));
        checkOutput({name, "_latency"}, cycle - start_cycle, e.lat);
    endtask

    // Monitors: a run is reported when done or err rises.
    always @(negedge clk) begin
        if (!rst && (done1 | err1) && !prev1) begin
            if (q1.size() == 0) checkOutput("dut1_unexpected_finish", 1, 0);
            else begin
                e1 = q1.pop_front();
                checkRun("dut1", e1, err1, done1, x1, y1, z1, iter1);
            end
        end
        prev1 = done1 | err1;
    end

    always @(negedge clk) begin
        if (!rst && (done2 | err2) && !prev2) begin
            if (q2.size() == 0) checkOutput("dut2_unexpected_finish", 1, 0);
            else begin
                e2 = q2.pop_front();
                checkRun("dut2", e2, err2, done2, x2, y2, z2, iter2);
            end
        end
        prev2 = done2 | err2;
    end

    function automatic exp_t mk(input bit er, input int x, input int y, input int z,
                                input int it, input int lat);
        exp_t e;
        e.er  = er;
        e.x   = 8'(x);
        e.y   = 8'(y);
        e.z   = 8'(z);
        e.it  = 4'(it);
        e.lat = lat;
        return e;
    endfunction

    task automatic waitScoreboards();
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q1.size() != 0 || q2.size() != 0) begin
            checkOutput("run_timeout", q1.size() + q2.size(), 0);
            q1.delete();
            q2.delete();
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] cv,
                                 input bit use1, input exp_t x1e, input bit use2, input exp_t x2e,
                                 input int pulse_at);
        @(negedge clk);
        a           = av;
        b           = bv;
        c           = cv;
        start       = 1'b1;
        start_cycle = cycle + 1;
        if (use1) q1.push_back(x1e);
        if (use2) q2.push_back(x2e);
        @(negedge clk);
        start = 1'b0;
        if (pulse_at > 0) begin
            repeat (pulse_at) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        waitScoreboards();
    endtask

    task automatic resetDut();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, "_busy1"}, int'(busy1), 0);
        checkOutput({name, "_done1"}, int'(done1), 0);
        checkOutput({name, "_err1"},  int'(err1),  0);
        checkOutput({name, "_prop1"}, int'(prop1), 1);
        checkOutput({name, "_lok1"},  int'(lok1),  1);
        checkOutput({name, "_xyz1"},  int'({x1, y1, z1}), 0);
        checkOutput({name, "_iter1"}, int'(iter1), 0);
        checkOutput({name, "_busy2"}, int'(busy2), 0);
        checkOutput({name, "_prop2"}, int'(prop2), 1);
        checkOutput({name, "_xyz2"},  int'({x2, y2, z2}), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c     = '0;
        resetDut();

        // Reset then idle with start low.
        repeat (10) @(negedge clk);
        checkIdle("idle");

        // THEN path with a=0: Y takes the constant 2.
        applyStimulus(8'd0, 8'd3, 8'd4, 1, mk(0, 0, 2, 2, 1, 7), 1, mk(0, 0, 2, 2, 2, 12), 0);
        // Restart from OK, THEN skipped; Y and Z must be cleared by INIT.
        applyStimulus(8'd5, 8'd9, 8'd7, 1, mk(0, 3, 0, 0, 1, 5), 1, mk(0, 6, 0, 0, 2, 8), 0);
        // Same run with a start pulse during TESTB: no effect on result or latency.
        applyStimulus(8'd5, 8'd9, 8'd7, 1, mk(0, 3, 0, 0, 1, 5), 1, mk(0, 6, 0, 0, 2, 8), 2);
        // Sum wraps: 3+255=2, 6+255=5.
        applyStimulus(8'd1, 8'd0, 8'd255, 1, mk(0, 3, 255, 2, 1, 7), 1, mk(0, 6, 255, 2, 2, 12), 0);
        // 6+254 wraps to TARGET for the two-pass instance only.
        applyStimulus(8'd1, 8'd0, 8'd254, 1, mk(0, 3, 254, 2, 1, 7), 1, mk(1, 6, 254, 2, 2, 12), 0);
        // 3+1 hits TARGET for the one-pass instance; the other is stuck in ERR.
        applyStimulus(8'd1, 8'd0, 8'd1, 1, mk(1, 3, 1, 2, 1, 7), 0, mk(0, 0, 0, 0, 0, 0), 0);

        // ERR is absorbing through a further start.
        @(negedge clk);
        a     = 8'd5;
        b     = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("absorb_err1",  int'(err1),  1);
        checkOutput("absorb_prop1", int'(prop1), 0);
        checkOutput("absorb_busy1", int'(busy1), 0);
        checkOutput("absorb_x1",    int'(x1),    3);
        checkOutput("absorb_y1",    int'(y1),    1);
        checkOutput("absorb_err2",  int'(err2),  1);
        checkOutput("absorb_x2",    int'(x2),    6);
        checkOutput("absorb_y2",    int'(y2),    254);

        // Asynchronous reset while both instances sit in THEN.
        resetDut();
        @(negedge clk);
        a     = 8'd1;
        b     = 8'd0;
        c     = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mid_busy_before", int'(busy1), 1);
        checkOutput("mid_x_before",    int'(x1),    3);
        #1 rst = 1'b1;
        #1;
        checkIdle("mid_reset");
        @(negedge clk);
        rst = 1'b0;

        // Normal operation resumes.
        applyStimulus(8'd0, 8'd3, 8'd4, 1, mk(0, 0, 2, 2, 1, 7), 1, mk(0, 0, 2, 2, 2, 12), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
